// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM encoding, instruction width,
// the canonical bubble instruction and a small PC helper.
package mips_pkg;

    localparam int INSTR_W = 32;

    // sll $0,$0,0 -- architectural no-op presented in empty pipeline slots
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // S_FETCH: normal operation
    // S_KILL : a request is outstanding whose data must be thrown away
    typedef enum logic {
        S_FETCH = 1'b0,
        S_KILL  = 1'b1
    } fetch_state_t;

    // One fetched instruction together with its link / branch base address
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc4;
    } fetch_word_t;

    // Sequential successor of a PC; wraps modulo 2^32
    function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;
    import mips_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/mux32bit_2to1.sv
// Library cell: 32-bit two-input multiplexer, y = sel ? b : a.
module mux32bit_2to1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage. Owns the PC, runs the req/ack handshake
// to instruction memory, keeps a one-entry skid buffer so an ack that
// lands during a stall is never lost, and loads the IF/ID register.
// A redirect that arrives while a request is in flight cannot cancel the
// bus transaction, so the FSM parks in S_KILL until that ack arrives and
// then discards its data.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                jump,
    input  logic [31:0]         jump_target,
    fetch_stage_if.master       imem,
    output logic                if_id_valid,
    output logic [31:0]         if_id_instr,
    output logic [31:0]         if_id_pc_plus4
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redir_q, redir_d;
    logic         req_q, req_d;
    logic         skid_v_q, skid_v_d;
    fetch_word_t  skid_q, skid_d;
    logic         ifid_v_q, ifid_v_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;

    logic [31:0]  pc_seq;
    logic [31:0]  pc_jmp;
    logic [31:0]  pc_next;
    logic         jump_eff;
    logic         redirect;
    logic         accepted;

    // A jump decoded from a bubble slot is not a real instruction
    assign jump_eff = jump & ifid_v_q;
    assign redirect = branch_taken | jump_eff;
    assign accepted = req_q & imem.imem_ack;
    assign pc_seq   = pc_plus4(pc_q);

    // Sequential vs jump; the branch mux sits last so an older EX branch
    // overrides a younger ID jump in the same cycle
    mux32bit_2to1 u_mux_jump (
        .a   (pc_seq),
        .b   (jump_target),
        .sel (jump_eff),
        .y   (pc_jmp)
    );

    mux32bit_2to1 u_mux_branch (
        .a   (pc_jmp),
        .b   (branch_target),
        .sel (branch_taken),
        .y   (pc_next)
    );

    // Next-state logic for PC, redirect latch, skid buffer and IF/ID
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = redir_q;
        skid_v_d     = skid_v_q;
        skid_d       = skid_q;
        ifid_v_d     = ifid_v_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    // Redirect beats stall; everything younger is squashed
                    skid_v_d     = 1'b0;
                    ifid_v_d     = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    if (!req_q || accepted) begin
                        pc_d = pc_next;
                    end else begin
                        // Address must stay put until the ack, so remember
                        // the target and throw the in-flight word away
                        redir_d = pc_next;
                        state_d = S_KILL;
                    end
                end else if (stall) begin
                    if (accepted) begin
                        skid_v_d = 1'b1;
                        skid_d   = '{instr: imem.imem_rdata, pc4: pc_seq};
                        pc_d     = pc_next;
                    end
                end else if (skid_v_q) begin
                    // Drain the word that arrived during the stall
                    ifid_v_d     = 1'b1;
                    ifid_instr_d = skid_q.instr;
                    ifid_pc4_d   = skid_q.pc4;
                    skid_v_d     = 1'b0;
                end else if (accepted) begin
                    ifid_v_d     = 1'b1;
                    ifid_instr_d = imem.imem_rdata;
                    ifid_pc4_d   = pc_seq;
                    pc_d         = pc_next;
                end else begin
                    // Memory still busy: hand decode a bubble
                    ifid_v_d     = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end

            S_KILL: begin
                ifid_v_d     = 1'b0;
                ifid_instr_d = NOP_INSTR;
                if (redirect) begin
                    redir_d = pc_next;
                end
                if (accepted) begin
                    pc_d    = redirect ? pc_next : redir_q;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A full skid blocks new requests; otherwise a request is always
        // in progress (an outstanding one is never dropped)
        req_d = ~skid_v_d;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, redirect latch and request flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            redir_q <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            redir_q <= redir_d;
            req_q   <= req_d;
        end
    end

    // Skid buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_v_q <= 1'b0;
            skid_q   <= '0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_v_q     <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0000_0000;
        end else begin
            ifid_v_q     <= ifid_v_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_id_valid    = ifid_v_q;
    assign if_id_instr    = ifid_instr_q;
    assign if_id_pc_plus4 = ifid_pc4_q;

endmodule
